// File: rtl/gcd_pkg.sv
// Shared types for the GCD core and its stream front-end.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } gcd_adp_state_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO; pointers wrap modulo DEPTH (power of 2).
module gcd_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 68
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/gcd_stream_adapter.sv
// Stream front-end for the GCD core: queues tagged operand pairs, drives the core
// one request at a time and returns tagged results in order.
module gcd_stream_adapter
    import gcd_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [XLEN-1:0]        req_a_i,
    input  logic [XLEN-1:0]        req_b_i,
    input  logic [TAG_W-1:0]       req_tag_i,
    output logic                   core_ld_o,
    output logic [XLEN-1:0]        core_a_o,
    output logic [XLEN-1:0]        core_b_o,
    input  logic                   core_done_i,
    input  logic [XLEN-1:0]        core_gcd_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [XLEN-1:0]        rsp_gcd_o,
    output logic [TAG_W-1:0]       rsp_tag_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
    } gcd_req_t;

    gcd_req_t         req_in;
    gcd_req_t         head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head_zero;
    gcd_adp_state_t   state;
    logic [TAG_W-1:0] tag_r;
    logic [XLEN-1:0]  rsp_gcd_r;
    logic [TAG_W-1:0] rsp_tag_r;

    always_comb begin
        req_in.tag = req_tag_i;
        req_in.a   = req_a_i;
        req_in.b   = req_b_i;
    end

    assign req_ready_o = !fifo_full;
    assign fifo_push   = req_valid_i && !fifo_full;
    assign head_zero   = (head.a == '0) || (head.b == '0);
    // Zero-operand heads leave straight from IDLE; all others leave during LOAD.
    assign fifo_pop    = (state == LOAD) || ((state == IDLE) && !fifo_empty && head_zero);

    gcd_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(gcd_req_t))
    ) u_req_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (fifo_push),
        .wdata_i (req_in),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tag_r     <= '0;
            rsp_gcd_r <= '0;
            rsp_tag_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_zero) begin
                            rsp_gcd_r <= head.a | head.b;
                            rsp_tag_r <= head.tag;
                            state     <= RESP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    tag_r <= head.tag;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done_i) begin
                        rsp_gcd_r <= core_gcd_i;
                        rsp_tag_r <= tag_r;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_ld_o   = (state == LOAD);
    assign core_a_o    = core_ld_o ? head.a : '0;
    assign core_b_o    = core_ld_o ? head.b : '0;
    assign rsp_valid_o = (state == RESP);
    assign rsp_gcd_o   = rsp_gcd_r;
    assign rsp_tag_o   = rsp_tag_r;
    assign busy_o      = (state != IDLE) || !fifo_empty;

endmodule
